apb_master_ctrl: RTL and testbench
==================================

// Module: apb_master_ctrl
// PURPOSE
//  APB requester: converts a simple command/response interface into APB SETUP/ACCESS
//  transfers and returns read data, slave error and timeout status. Drives the APB
//  slaves in this subsystem (e.g. the 32-word APB RAM) and sits between the local
//  controller and the APB bus. One outstanding transfer at a time.
// PARAMETERS
//  AW       32  address width (paddr, cmd_addr)
//  DW       32  data width (pwdata, prdata, cmd_wdata, rsp_rdata)
//  TIMEOUT  16  max ACCESS cycles waiting for pready before abort; 0 = never time out
// PORTS
//  pclk         in   1   clock, all logic on rising edge
//  presetn      in   1   reset, asynchronous, active-low
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   command accepted when cmd_valid&&cmd_ready
//  cmd_write    in   1   1=write, 0=read
//  cmd_addr     in   AW  transfer address
//  cmd_wdata    in   DW  write data
//  rsp_valid    out  1   one-cycle response strobe
//  rsp_rdata    out  DW  read data (0 for writes, timeouts and errored reads)
//  rsp_err      out  1   pslverr sampled with pready, or timeout
//  rsp_timeout  out  1   transfer aborted by TIMEOUT
//  psel         out  1   APB select
//  penable      out  1   APB enable
//  pwrite       out  1   APB direction
//  paddr        out  AW  APB address
//  pwdata       out  DW  APB write data
//  prdata       in   DW  APB read data
//  pready       in   1   APB ready
//  pslverr      in   1   APB slave error
// BEHAVIOUR
//  Reset: every output 0 (cmd_ready 0 while presetn low), state IDLE, wait counter 0.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE:   cmd_ready=1, psel=0, penable=0. On cmd_valid: latch write/addr/wdata into
//           pwrite/paddr/pwdata (pwdata=0 for reads) -> SETUP.
//   SETUP:  psel=1, penable=0, exactly one cycle -> ACCESS.
//   ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable. Each cycle with pready=0
//           increments wait counter. pready=1: capture prdata (reads only) and
//           pslverr -> RESP. If TIMEOUT!=0 and counter==TIMEOUT with pready=0: abort,
//           rsp_err=1, rsp_timeout=1 -> RESP. pready and timeout in the same cycle:
//           pready wins.
//   RESP:   psel=0, penable=0, rsp_valid=1 for exactly one cycle -> IDLE; counter
//           cleared. cmd_ready=0 here (no back-to-back without an IDLE cycle).
//  Latency: accept at cycle N, SETUP N+1, ACCESS N+2; pready at N+2+k -> rsp_valid at
//   N+3+k. Minimum 4 cycles command to next cmd_ready.
//  rsp_rdata/rsp_err/rsp_timeout valid only with rsp_valid; otherwise 0.
//  paddr/pwdata/pwrite hold last values in IDLE (no toggling when psel=0).
//  Errored read (pslverr=1): rsp_rdata forced 0, prdata (possibly X) never propagated.
//  Counter saturates at TIMEOUT; width $clog2(TIMEOUT+1), min 1 bit.
//  presetn low mid-transfer: immediate return to IDLE outputs, psel/penable drop
//   asynchronously, no response issued for the aborted command.
//  cmd_valid outside IDLE ignored (no buffering).
// STRUCTURE
//  Package apb_pkg: apb_state_e {IDLE,SETUP,ACCESS,RESP}, default AW/DW constants,
//   shared with APB slaves in the subsystem.
//  Single module; optional sub-module apb_wait_timer (counter + timeout compare).
// TESTING
//  Write 0x5 <- 0xDEADBEEF, pready=1 on first ACCESS -> SETUP then ACCESS once,
//   rsp_valid 3 cycles after accept, rsp_err=0; RAM read-back returns 0xDEADBEEF.
//  Read 0x5, slave adds 3 wait states -> penable held 4 cycles, paddr stable,
//   rsp_rdata=0xDEADBEEF, rsp_err=0.
//  Write 0x40 (out of range, slave pslverr=1) -> rsp_err=1, rsp_timeout=0; read
//   0x40 -> rsp_rdata=0, rsp_err=1.
//  TIMEOUT=16, pready tied 0 -> abort after 16 ACCESS cycles, rsp_err=1,
//   rsp_timeout=1, psel drops, cmd_ready returns next cycle.
//  presetn asserted during ACCESS -> psel/penable 0 same cycle, no rsp_valid, next
//   command after reset completes normally.
//  cmd_valid held high for 3 commands -> each accepted only in IDLE, rsp_valid
//   pulses once per command, in order.

Source files
------------

// File: rtl/apb_master_ctrl_pkg.sv
// Shared APB definitions: state encoding, default bus widths and a helper for
// sizing the ACCESS wait counter. Used by the requester and the APB slaves.
package apb_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Plain vector constants of the same encoding, for state registers kept as logic
  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  // Counter width able to hold 0..timeout; at least one bit when timeout is disabled
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command/response side and APB side of the requester bundled in one interface.
// master: the requester's view. slave: the local controller plus APB completer view.
interface apb_master_ctrl_if #(
  parameter int unsigned AW = apb_pkg::APB_AW,
  parameter int unsigned DW = apb_pkg::APB_DW
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_ctrl_timer.sv
// ACCESS-phase wait counter. Counts cycles without pready, saturates at TIMEOUT,
// and flags expiry on the cycle whose stall brings the count up to TIMEOUT, so a
// never-ready completer sees exactly TIMEOUT ACCESS cycles. TIMEOUT=0 disables it.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam int unsigned   CW    = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic          ARMED = (TIMEOUT != 0);

  logic [CW-1:0] count_reg;

  // Stall counter: cleared outside ACCESS, frozen once it reaches the limit
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en && (count_reg != LIMIT)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expire = ARMED && count_en && (count_reg == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: turns one command at a time into an APB SETUP/ACCESS transfer
// and returns a single-cycle response with read data, slave error and timeout.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned AW      = APB_AW,
  parameter int unsigned DW      = APB_DW,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               pclk,
  input logic               presetn,
  apb_master_ctrl_if.master bus
);

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic          pwrite_reg;
  logic [AW-1:0] paddr_reg;
  logic [DW-1:0] pwdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          err_reg;
  logic          tout_reg;

  logic in_idle;
  logic in_access;
  logic in_resp;
  logic accept;
  logic wait_en;
  logic wait_clr;
  logic expire;

  assign in_idle   = (state_reg == ST_IDLE);
  assign in_access = (state_reg == ST_ACCESS);
  assign in_resp   = (state_reg == ST_RESP);
  assign accept    = in_idle && bus.cmd_valid;
  assign wait_en   = in_access && !bus.pready;
  assign wait_clr  = !in_access;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .pclk     (pclk),
    .presetn  (presetn),
    .count_en (wait_en),
    .clear    (wait_clr),
    .expire   (expire)
  );

  // Transfer sequencing; pready is tested before expiry so it wins a tie
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.cmd_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (bus.pready || expire) state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register; reset drops psel/penable immediately and discards the transfer
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request fields latched on accept and held afterwards so the bus stays quiet in IDLE
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite_reg <= 1'b0;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
    end else if (accept) begin
      pwrite_reg <= bus.cmd_write;
      paddr_reg  <= bus.cmd_addr;
      pwdata_reg <= bus.cmd_write ? bus.cmd_wdata : '0;
    end
  end

  // Completion capture; prdata is only taken for clean reads so errored data never leaks
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      tout_reg  <= 1'b0;
    end else if (in_access && bus.pready) begin
      rdata_reg <= (!pwrite_reg && !bus.pslverr) ? bus.prdata : '0;
      err_reg   <= bus.pslverr;
      tout_reg  <= 1'b0;
    end else if (in_access && expire) begin
      rdata_reg <= '0;
      err_reg   <= 1'b1;
      tout_reg  <= 1'b1;
    end
  end

  assign bus.cmd_ready   = presetn && in_idle;
  assign bus.psel        = (state_reg == ST_SETUP) || in_access;
  assign bus.penable     = in_access;
  assign bus.pwrite      = pwrite_reg;
  assign bus.paddr       = paddr_reg;
  assign bus.pwdata      = pwdata_reg;
  assign bus.rsp_valid   = in_resp;
  assign bus.rsp_rdata   = in_resp ? rdata_reg : '0;
  assign bus.rsp_err     = in_resp && err_reg;
  assign bus.rsp_timeout = in_resp && tout_reg;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: a 32-word APB RAM completer with
// programmable wait states, directed cases plus randomized traffic, all checked
// against a transaction-level model of memory contents, errors and timing.
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int TMO = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_ctrl_if #(.AW(32), .DW(32)) bus ();

  apb_master_ctrl #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  // ---------------- APB RAM completer ----------------
  logic [31:0] slave_mem [0:31];
  int   acc_cnt = 0;
  int   cur_waits = 0;
  logic in_range;

  always_comb begin
    in_range    = (bus.paddr < 32);
    bus.pready  = bus.psel && bus.penable && (acc_cnt >= cur_waits);
    bus.pslverr = bus.pready && !in_range;
    if (bus.pready && !bus.pwrite && in_range) bus.prdata = slave_mem[bus.paddr[4:0]];
    else                                       bus.prdata = 32'hBAD0_0BAD;
  end

  always @(posedge pclk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else                                        acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && in_range)
      slave_mem[bus.paddr[4:0]] <= bus.pwdata;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:31];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command at a negedge in IDLE, follow it to its response, return at the
  // next negedge (back in IDLE). waits = stall cycles before pready; >= TMO means abort.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input bit hold);
    bit tmo, err, proto_ok, got_rsp;
    int acc, idx, pen_cnt;
    logic [31:0] exp_rdata, exp_pwdata;

    tmo        = (waits >= TMO);
    acc        = tmo ? TMO : waits + 1;
    err        = tmo || (addr >= 32);
    exp_pwdata = wr ? wdata : 32'h0;
    exp_rdata  = (!wr && !err) ? ref_mem[addr[4:0]] : 32'h0;
    if (wr && !err) ref_mem[addr[4:0]] = wdata;

    cur_waits     = waits;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    check_val("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge pclk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;

    idx = 0; pen_cnt = 0; proto_ok = 1'b1; got_rsp = 1'b0;
    while (idx < 200) begin
      @(negedge pclk);
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
        break;
      end
      if (bus.psel !== 1'b1 || bus.penable !== (idx != 0)) proto_ok = 1'b0;
      if (bus.penable) pen_cnt++;
      if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== exp_pwdata) proto_ok = 1'b0;
      if (bus.rsp_err || bus.rsp_timeout || (bus.rsp_rdata != 0) || bus.cmd_ready) proto_ok = 1'b0;
      idx++;
    end

    check_val("rsp_seen", got_rsp, 1);
    if (got_rsp) begin
      check_val("rsp_latency", idx, acc + 1);
      check_val("access_cycles", pen_cnt, acc);
      check_val("bus_protocol", proto_ok, 1);
      check_val("rsp_rdata", bus.rsp_rdata, exp_rdata);
      check_val("rsp_err", bus.rsp_err, err);
      check_val("rsp_timeout", bus.rsp_timeout, tmo);
      check_val("resp_idle_bus", {bus.psel, bus.penable, bus.cmd_ready}, 3'b000);
      $display("txn %0d wr=%0b addr=0x%0h waits=%0d rdata=0x%08h err=%0b tout=%0b",
               txn_no, wr, addr, waits, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
      @(negedge pclk);
      check_val("rsp_one_cycle", bus.rsp_valid, 0);
      check_val("ready_after_resp", bus.cmd_ready, 1);
      check_val("paddr_hold", bus.paddr, addr);
    end
    txn_no++;
  endtask

  initial begin
    bit seen_rsp;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // Reset state
    #2;
    check_val("rst_cmd_ready", bus.cmd_ready, 0);
    check_val("rst_bus", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}, 4'b0000);
    check_val("rst_paddr", bus.paddr, 0);
    check_val("rst_rsp", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 0);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check_val("post_rst_ready", bus.cmd_ready, 1);

    // Preload every RAM word so later reads have a defined expectation
    for (int i = 0; i < 32; i++) do_txn(1'b1, i, $urandom, 0, 1'b0);

    // Directed cases
    do_txn(1'b1, 32'h5, 32'hDEADBEEF, 0, 1'b0);
    do_txn(1'b0, 32'h5, 32'h0, 3, 1'b0);
    do_txn(1'b1, 32'h40, 32'h1234_5678, 0, 1'b0);
    do_txn(1'b0, 32'h40, 32'h0, 1, 1'b0);
    do_txn(1'b1, 32'h9, 32'hCAFE_F00D, 1000, 1'b0);
    do_txn(1'b0, 32'h9, 32'h0, TMO - 1, 1'b0);
    do_txn(1'b0, 32'h9, 32'h0, TMO, 1'b0);

    // Reset asserted during ACCESS: bus drops at once, no response, write not committed
    cur_waits     = 1000;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h7;
    bus.cmd_wdata = 32'h0BAD_CAFE;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge pclk);
    check_val("pre_rst_penable", bus.penable, 1);
    #1;
    presetn = 1'b0;
    #1;
    check_val("async_rst_bus", {bus.psel, bus.penable, bus.cmd_ready}, 3'b000);
    seen_rsp = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      seen_rsp |= bus.rsp_valid;
    end
    presetn = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      seen_rsp |= bus.rsp_valid;
    end
    check_val("no_rsp_after_rst", seen_rsp, 0);
    check_val("ready_after_rst", bus.cmd_ready, 1);
    do_txn(1'b0, 32'h7, 32'h0, 2, 1'b0);

    // cmd_valid held high across three commands
    do_txn(1'b1, 32'h3, 32'hA5A5_5A5A, 0, 1'b1);
    do_txn(1'b0, 32'h3, 32'h0, 2, 1'b1);
    do_txn(1'b1, 32'h80, 32'h1111_2222, 1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      logic [31:0] addr;
      int          waits;
      int          r;
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      addr = (r == 0) ? 32'h40 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 31));
      r = $urandom_range(0, 19);
      if (r == 0)      waits = TMO + $urandom_range(0, 4);
      else if (r == 1) waits = TMO - 1;
      else             waits = $urandom_range(0, 3);
      do_txn(wr, addr, $urandom, waits, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
